// File: rtl/hamming_frame_sched.sv
// Sequencer for the Hamming(7,4) frame decoder: collects a serial coded frame,
// hands the 56 code bits to an external 8-lane decoder, latches the result and
// streams the 32 decoded bits out while the next frame is being collected.
module hamming_frame_sched #(
    parameter int FRAME_BITS = 64,
    parameter int NUM_CW     = 8,
    parameter int DATA_BITS  = 32,
    parameter int CNT_W      = 16
) (
    input  logic                   clk_decoder,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic                   in_data,
    output logic                   in_ready,
    output logic [NUM_CW*7-1:0]    dec_cw,
    input  logic [DATA_BITS-1:0]   dec_data,
    input  logic [NUM_CW-1:0]      dec_err,
    output logic                   out_valid,
    output logic                   out_data,
    output logic                   out_sof,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       err_count,
    output logic [CNT_W-1:0]       frame_count
);

    localparam int CW_BITS = NUM_CW * 7;
    localparam int IDX_W   = $clog2(FRAME_BITS);
    localparam int OCNT_W  = $clog2(DATA_BITS);

    typedef enum logic [1:0] {O_EMPTY, O_DECODE, O_SEND} ostate_t;

    // Only the code bits are stored; the leading padding bits are counted but dropped.
    logic [CW_BITS-1:0]   in_buf_q, in_buf_d;
    logic [IDX_W-1:0]     in_cnt_q, in_cnt_d;
    logic                 in_full_q, in_full_d;
    logic [CW_BITS-1:0]   cw_reg_q, cw_reg_d;
    ostate_t              ostate_q, ostate_d;
    logic [DATA_BITS-1:0] out_buf_q, out_buf_d;
    logic [OCNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]     err_count_q, err_count_d;
    logic [CNT_W-1:0]     frame_count_q, frame_count_d;

    logic [IDX_W-1:0]     wr_idx;
    logic [OCNT_W-1:0]    rd_idx;
    logic [CNT_W:0]       err_sum;

    // First serial bit lands in the MSB; output is sent MSB first.
    assign wr_idx  = IDX_W'(FRAME_BITS - 1) - in_cnt_q;
    assign rd_idx  = OCNT_W'(DATA_BITS - 1) - out_cnt_q;
    assign err_sum = {1'b0, err_count_q} + (CNT_W+1)'($countones(dec_err));

    // State register for all sequencing and datapath flops.
    always_ff @(posedge clk_decoder or negedge rst_n) begin
        if (!rst_n) begin
            in_buf_q      <= '0;
            in_cnt_q      <= '0;
            in_full_q     <= 1'b0;
            cw_reg_q      <= '0;
            ostate_q      <= O_EMPTY;
            out_buf_q     <= '0;
            out_cnt_q     <= '0;
            err_count_q   <= '0;
            frame_count_q <= '0;
        end else begin
            in_buf_q      <= in_buf_d;
            in_cnt_q      <= in_cnt_d;
            in_full_q     <= in_full_d;
            cw_reg_q      <= cw_reg_d;
            ostate_q      <= ostate_d;
            out_buf_q     <= out_buf_d;
            out_cnt_q     <= out_cnt_d;
            err_count_q   <= err_count_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Next state: input collection, frame transfer and output sequencing; flush wins.
    always_comb begin
        in_buf_d      = in_buf_q;
        in_cnt_d      = in_cnt_q;
        in_full_d     = in_full_q;
        cw_reg_d      = cw_reg_q;
        ostate_d      = ostate_q;
        out_buf_d     = out_buf_q;
        out_cnt_d     = out_cnt_q;
        err_count_d   = err_count_q;
        frame_count_d = frame_count_q;
        if (flush) begin
            in_cnt_d  = '0;
            in_full_d = 1'b0;
            ostate_d  = O_EMPTY;
            out_cnt_d = '0;
        end else begin
            // Accept and transfer are exclusive: accept needs !in_full, transfer needs in_full.
            if (in_valid && !in_full_q) begin
                if (wr_idx < IDX_W'(CW_BITS))
                    in_buf_d[wr_idx] = in_data;
                in_cnt_d = in_cnt_q + 1'b1;
                if (in_cnt_q == IDX_W'(FRAME_BITS - 1))
                    in_full_d = 1'b1;
            end
            case (ostate_q)
                O_EMPTY: begin
                    if (in_full_q) begin
                        cw_reg_d  = in_buf_q;
                        in_full_d = 1'b0;
                        ostate_d  = O_DECODE;
                    end
                end
                O_DECODE: begin
                    out_buf_d     = dec_data;
                    err_count_d   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
                    frame_count_d = frame_count_q + 1'b1;
                    out_cnt_d     = '0;
                    ostate_d      = O_SEND;
                end
                O_SEND: begin
                    if (out_ready) begin
                        out_cnt_d = out_cnt_q + 1'b1;
                        if (out_cnt_q == OCNT_W'(DATA_BITS - 1))
                            ostate_d = O_EMPTY;
                    end
                end
                default: ostate_d = O_EMPTY;
            endcase
        end
    end

    // Outputs decoded from the registered state only; no combinational bypass.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 1'b0;
        out_sof   = 1'b0;
        if (ostate_q == O_SEND) begin
            out_valid = 1'b1;
            out_data  = out_buf_q[rd_idx];
            out_sof   = (out_cnt_q == '0);
        end
    end

    assign in_ready    = !in_full_q;
    assign dec_cw      = cw_reg_q;
    assign err_count   = err_count_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_hamming_frame_sched.sv
// Bench for hamming_frame_sched: randomized frames against a frame-level model
// (bit queues, arithmetic counters, latency rule) plus a decoder stub.
module tb_hamming_frame_sched;

    // Narrow counters so saturation and wrap are reachable in a short run.
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk_decoder = 1'b0;
    logic              rst_n = 1'b0, flush = 1'b0;
    logic              in_valid = 1'b0, in_data = 1'b0, out_ready = 1'b0;
    logic              in_ready, out_valid, out_data, out_sof;
    logic [55:0]       dec_cw;
    logic [31:0]       dec_data;
    logic [7:0]        dec_err;
    logic [CNT_W-1:0]  err_count, frame_count;

    always #5 clk_decoder = ~clk_decoder;

    hamming_frame_sched #(.CNT_W(CNT_W)) dut (
        .clk_decoder(clk_decoder), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .dec_cw(dec_cw), .dec_data(dec_data), .dec_err(dec_err),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
        .out_ready(out_ready), .err_count(err_count), .frame_count(frame_count)
    );

    // Decoder stub: fixed values or a simple function of the code bits.
    logic        fix_en = 1'b0;
    logic [31:0] fix_data = '0;
    logic [7:0]  fix_err = '0;
    function automatic logic [31:0] ref_data(input logic [55:0] c);
        return c[31:0] ^ {c[55:32], 8'h5A};
    endfunction
    function automatic logic [7:0] ref_err(input logic [55:0] c);
        return c[7:0] ^ c[55:48];
    endfunction
    assign dec_data = fix_en ? fix_data : ref_data(dec_cw);
    assign dec_err  = fix_en ? fix_err  : ref_err(dec_cw);

    typedef struct { logic d; logic s; int c; } obit_t;
    typedef struct { logic d; logic s; } ebit_t;

    obit_t got_q[$];
    ebit_t exp_q[$];
    logic  in_q[$];
    int    tlast_q[$];
    int    cyc = 0, in_cnt_m = 0, m_err = 0, m_frames = 0;
    int    checks = 0, errs = 0;
    logic  ordy = 1'b1;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Queue a frame for sending and record what the sink must see.
    task automatic gen_frame(input logic [63:0] f);
        logic [31:0] d;
        logic [7:0]  e;
        ebit_t       eb;
        for (int i = 63; i >= 0; i--) in_q.push_back(f[i]);
        d = fix_en ? fix_data : ref_data(f[55:0]);
        e = fix_en ? fix_err  : ref_err(f[55:0]);
        for (int i = 31; i >= 0; i--) begin
            eb.d = d[i];
            eb.s = (i == 31);
            exp_q.push_back(eb);
        end
        m_err = m_err + $countones(e);
        if (m_err > CMAX) m_err = CMAX;
        m_frames = (m_frames + 1) % (CMAX + 1);
    endtask

    // One clock: drive inputs, record handshakes seen at the edge.
    task automatic step();
        obit_t ob;
        in_valid  = (in_q.size() > 0);
        in_data   = (in_q.size() > 0) ? in_q[0] : 1'b0;
        out_ready = ordy;
        @(posedge clk_decoder);
        cyc++;
        if (flush) begin
            in_cnt_m = 0;
        end else begin
            if (in_valid && in_ready) begin
                void'(in_q.pop_front());
                if (in_cnt_m == 63) begin
                    tlast_q.push_back(cyc);
                    in_cnt_m = 0;
                end else begin
                    in_cnt_m++;
                end
            end
            if (out_valid && out_ready) begin
                ob.d = out_data; ob.s = out_sof; ob.c = cyc;
                got_q.push_back(ob);
            end
        end
        #1;
    endtask

    task automatic clr();
        got_q.delete(); exp_q.delete(); tlast_q.delete();
    endtask

    task automatic drain(input int budget, input string nm);
        int n = 0;
        ordy = 1'b1;
        while ((in_q.size() > 0 || got_q.size() < exp_q.size() || out_valid) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errs++;
            $display("FAIL %s drain: still busy after %0d cycles, got %0d of %0d bits",
                     nm, n, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        clr();
        gen_frame(rand64());
        drain(300, "reset_pre");
        for (int i = 0; i < 20; i++) in_q.push_back(1'($urandom));
        for (int i = 0; i < 20; i++) step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks += 7;
        if (in_ready !== 1'b1)  begin errs++; $display("FAIL reset in_ready: got %b need 1", in_ready); end
        if (out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid: got %b need 0", out_valid); end
        if (out_data !== 1'b0)  begin errs++; $display("FAIL reset out_data: got %b need 0", out_data); end
        if (out_sof !== 1'b0)   begin errs++; $display("FAIL reset out_sof: got %b need 0", out_sof); end
        if (dec_cw !== 56'h0)   begin errs++; $display("FAIL reset dec_cw: got %h need 0", dec_cw); end
        if (err_count !== '0)   begin errs++; $display("FAIL reset err_count: got %0d need 0", err_count); end
        if (frame_count !== '0) begin errs++; $display("FAIL reset frame_count: got %0d need 0", frame_count); end
        in_q.delete(); in_cnt_m = 0; m_err = 0; m_frames = 0;
        @(posedge clk_decoder); #1;
        rst_n = 1'b1;
        clr();
        gen_frame(rand64());
        drain(300, "reset_post");
        checks++;
        if (got_q.size() != 32) begin errs++; $display("FAIL reset_post count: got %0d need 32", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].s !== exp_q[i].s) begin
                errs++;
                $display("FAIL reset_post bit %0d: got d=%b sof=%b need d=%b sof=%b",
                         i, got_q[i].d, got_q[i].s, exp_q[i].d, exp_q[i].s);
            end
        end
        checks++;
        if (frame_count !== CNT_W'(1)) begin errs++; $display("FAIL reset_post frame_count: got %0d need 1", frame_count); end
    endtask

    task automatic test_single();
        logic [31:0] word;
        int          expc;
        clr();
        fix_en = 1'b1; fix_data = 32'hA5A5_3C3C; fix_err = 8'b0000_0101;
        gen_frame({8'hFF, {28{2'b10}}});
        drain(300, "single");
        checks++;
        if (dec_cw !== 56'hAA_AAAA_AAAA_AAAA) begin errs++; $display("FAIL single dec_cw: got %h need aaaaaaaaaaaaaa", dec_cw); end
        checks++;
        if (got_q.size() != 32) begin
            errs++; $display("FAIL single count: got %0d need 32", got_q.size());
        end else begin
            word = '0;
            for (int i = 0; i < 32; i++) word = {word[30:0], got_q[i].d};
            checks++;
            if (word !== 32'hA5A5_3C3C) begin errs++; $display("FAIL single stream: got %h need a5a53c3c", word); end
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (got_q[i].s !== (i == 0)) begin errs++; $display("FAIL single sof bit %0d: got %b", i, got_q[i].s); end
            end
            expc = tlast_q[0] + 3;
            checks++;
            if (got_q[0].c != expc) begin errs++; $display("FAIL single latency: first bit at %0d need %0d", got_q[0].c, expc); end
        end
        checks += 2;
        if (err_count !== CNT_W'(m_err)) begin errs++; $display("FAIL single err_count: got %0d need %0d", err_count, m_err); end
        if (frame_count !== CNT_W'(m_frames)) begin errs++; $display("FAIL single frame_count: got %0d need %0d", frame_count, m_frames); end
        fix_en = 1'b0;
    endtask

    task automatic test_backpressure();
        logic held;
        int   n;
        clr();
        gen_frame(rand64());
        gen_frame(rand64());
        ordy = 1'b1;
        n = 0;
        while (got_q.size() < 6 && n < 300) begin step(); n++; end
        ordy = 1'b0;
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
                errs++;
                $display("FAIL bp stall cycle %0d: valid=%b data=%b need valid=1 data=%b", i, out_valid, out_data, held);
            end
        end
        n = 0;
        while (tlast_q.size() < 2 && n < 300) begin step(); n++; end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b0) begin errs++; $display("FAIL bp in_ready while full: got %b need 0", in_ready); end
        end
        drain(300, "bp");
        checks++;
        if (got_q.size() != 64) begin
            errs++; $display("FAIL bp count: got %0d need 64", got_q.size());
        end else begin
            checks++;
            if (got_q[32].c - got_q[31].c != 3) begin
                errs++; $display("FAIL bp gap: %0d idle cycles need 2", got_q[32].c - got_q[31].c - 1);
            end
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (got_q[i].d !== exp_q[i].d || got_q[i].s !== exp_q[i].s) begin
                    errs++;
                    $display("FAIL bp bit %0d: got d=%b sof=%b need d=%b sof=%b",
                             i, got_q[i].d, got_q[i].s, exp_q[i].d, exp_q[i].s);
                end
            end
        end
        checks++;
        if (frame_count !== CNT_W'(m_frames)) begin errs++; $display("FAIL bp frame_count: got %0d need %0d", frame_count, m_frames); end
    endtask

    task automatic test_back_to_back();
        int prev, expc;
        clr();
        for (int k = 0; k < 3; k++) gen_frame(rand64());
        drain(600, "b2b");
        checks++;
        if (got_q.size() != 96 || tlast_q.size() != 3) begin
            errs++; $display("FAIL b2b count: got %0d bits %0d frames need 96 and 3", got_q.size(), tlast_q.size());
        end else begin
            for (int i = 0; i < 96; i++) begin
                checks++;
                if (got_q[i].d !== exp_q[i].d || got_q[i].s !== exp_q[i].s) begin
                    errs++;
                    $display("FAIL b2b bit %0d: got d=%b sof=%b need d=%b sof=%b",
                             i, got_q[i].d, got_q[i].s, exp_q[i].d, exp_q[i].s);
                end
            end
            // First bit = max(previous frame done + 1, last input + 1) + 2.
            for (int k = 0; k < 3; k++) begin
                prev = (k == 0) ? -100 : got_q[32*k-1].c;
                expc = ((prev + 1 > tlast_q[k] + 1) ? prev + 1 : tlast_q[k] + 1) + 2;
                checks++;
                if (got_q[32*k].c != expc) begin
                    errs++; $display("FAIL b2b frame %0d start: cycle %0d need %0d", k, got_q[32*k].c, expc);
                end
            end
        end
        checks++;
        if (frame_count !== CNT_W'(m_frames)) begin errs++; $display("FAIL b2b frame_count: got %0d need %0d", frame_count, m_frames); end
    endtask

    task automatic test_flush();
        logic [63:0] b;
        int          n;
        clr();
        gen_frame(rand64());
        b = rand64();
        for (int i = 63; i >= 0; i--) in_q.push_back(b[i]);
        ordy = 1'b1;
        n = 0;
        while (got_q.size() < 12 && n < 300) begin step(); n++; end
        ordy = 1'b0;
        n = 0;
        while (in_cnt_m < 40 && n < 300) begin step(); n++; end
        flush = 1'b1; ordy = 1'b1;
        step();
        flush = 1'b0;
        in_q.delete();
        checks += 5;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL flush out_valid: got %b need 0", out_valid); end
        if (in_ready !== 1'b1)  begin errs++; $display("FAIL flush in_ready: got %b need 1", in_ready); end
        if (got_q.size() != 12) begin errs++; $display("FAIL flush sent: got %0d bits need 12", got_q.size()); end
        if (err_count !== CNT_W'(m_err)) begin errs++; $display("FAIL flush err_count: got %0d need %0d", err_count, m_err); end
        if (frame_count !== CNT_W'(m_frames)) begin errs++; $display("FAIL flush frame_count: got %0d need %0d", frame_count, m_frames); end
        for (int i = 0; i < got_q.size() && i < 12; i++) begin
            checks++;
            if (got_q[i].d !== exp_q[i].d) begin errs++; $display("FAIL flush pre bit %0d: got %b need %b", i, got_q[i].d, exp_q[i].d); end
        end
        clr();
        gen_frame(rand64());
        drain(300, "flush_post");
        checks++;
        if (got_q.size() != 32) begin errs++; $display("FAIL flush_post count: got %0d need 32", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].s !== exp_q[i].s) begin
                errs++;
                $display("FAIL flush_post bit %0d: got d=%b sof=%b need d=%b sof=%b",
                         i, got_q[i].d, got_q[i].s, exp_q[i].d, exp_q[i].s);
            end
        end
        checks++;
        if (frame_count !== CNT_W'(m_frames)) begin errs++; $display("FAIL flush_post frame_count: got %0d need %0d", frame_count, m_frames); end
    endtask

    task automatic test_saturation();
        int nf;
        fix_en = 1'b1; fix_err = 8'hFF;
        nf = (CMAX + 1) - m_frames + 2;
        for (int k = 0; k < nf; k++) begin
            clr();
            fix_data = $urandom;
            gen_frame(rand64());
            drain(300, "sat");
            checks += 2;
            if (err_count !== CNT_W'(m_err)) begin errs++; $display("FAIL sat frame %0d err_count: got %0d need %0d", k, err_count, m_err); end
            if (frame_count !== CNT_W'(m_frames)) begin errs++; $display("FAIL sat frame %0d frame_count: got %0d need %0d", k, frame_count, m_frames); end
        end
        checks++;
        if (err_count !== CNT_W'(CMAX)) begin errs++; $display("FAIL sat stick: got %0d need %0d", err_count, CMAX); end
        fix_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk_decoder);
        #1 rst_n = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hamming_frame_sched.md
Name: hamming_frame_sched

Overview:
- Single-clock sequencing controller for the Hamming(7,4) frame decoder datapath.
- Accepts a serial 64-bit coded frame over a valid/ready handshake and presents the 56 code bits to an external combinational 8-lane decoder.
- Latches the 32 decoded data bits and the per-lane error flags, then serializes the data bits out over a second valid/ready handshake.
- Keeps saturating corrected-error and wrapping frame statistics. It sits between the line deserializer and the downstream data sink.

Parameters:
- FRAME_BITS, 64, serial bits per coded frame (fixed; the first 8 are padding)
- NUM_CW, 8, codewords per frame (fixed)
- DATA_BITS, 32, decoded bits per frame (fixed)
- CNT_W, 16, width of err_count and frame_count

Ports:
- clk_decoder  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any frame in flight
- in_valid  in  1  serial input bit valid
- in_data  in  1  serial input bit
- in_ready  out  1  controller can accept an input bit
- dec_cw  out  56  codeword bus to decoder; lane i = dec_cw[7i+6:7i]
- dec_data  in  32  decoder output; lane i = dec_data[4i+3:4i]
- dec_err  in  8  decoder per-lane nonzero-syndrome flags
- out_valid  out  1  serial output bit valid
- out_data  out  1  serial output bit
- out_sof  out  1  high with the first output bit of each frame
- out_ready  in  1  sink accepts the output bit
- err_count  out  CNT_W  saturating total of corrected lanes
- frame_count  out  CNT_W  decoded frames, wraps

Behaviour:
- Reset (rst_n low, async):
  - in_cnt=0, in_full=0, ostate=O_EMPTY, cw_reg=0, out_buf=0, out_cnt=0, counters=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=0, out_sof=0, dec_cw=0.
  - Reset mid-frame discards all partial data.
- Input side:
  - in_ready = !in_full.
  - An accepted bit (in_valid && in_ready) with index k = in_cnt is written to in_buf[63-k], then in_cnt increments.
  - On accepting k=63: in_cnt wraps to 0 and in_full<=1.
  - in_buf[63:56] (first 8 bits received) is padding and ignored.
- Transfer: when in_full && ostate==O_EMPTY: cw_reg<=in_buf[55:0], in_full<=0, ostate<=O_DECODE. dec_cw = cw_reg at all times.
- Output FSM:
  - O_EMPTY: out_valid=0; waits for a transfer.
  - O_DECODE (exactly 1 cycle):
    - out_buf<=dec_data.
    - err_count<=min(err_count+popcount(dec_err), 2^CNT_W-1).
    - frame_count<=frame_count+1 (mod 2^CNT_W).
    - out_cnt<=0; go to O_SEND.
  - O_SEND:
    - out_valid=1, out_data=out_buf[31-out_cnt], out_sof=(out_cnt==0).
    - On out_valid && out_ready: out_cnt++. If out_cnt==31 the frame is done and the FSM goes to O_EMPTY.
    - out_data holds stable while out_ready is low.
- Latency: the last input bit is accepted in cycle T. Transfer happens in T+1, O_DECODE in T+2, and first out_valid in T+3, provided the FSM was O_EMPTY.
- Overlap and backpressure:
  - The next frame is collected while O_SEND runs.
  - When it completes, in_full holds in_ready=0 until the FSM returns to O_EMPTY. The transfer then occurs that cycle.
  - Minimum gap between frames on out_valid: 2 idle cycles (O_EMPTY→transfer, O_DECODE).
- flush (synchronous):
  - Priority over accept, transfer and send.
  - Sets in_cnt=0, in_full=0, ostate=O_EMPTY, out_cnt=0.
  - Input bits offered in the flush cycle are dropped.
  - err_count and frame_count are retained; a frame in O_DECODE during flush is not counted.
- Simultaneous events: a final output handshake (out_cnt==31) and in_full==1 in the same cycle → O_EMPTY next cycle, then transfer the cycle after. No combinational bypass.
- err_count saturates at all-ones and never wraps. frame_count wraps to 0.

Test Plan:
- Reset and idle: assert rst_n low mid-frame (after 20 bits), release → in_ready=1, out_valid=0, dec_cw=0, counters 0. Then a full frame decodes normally from bit 0.
- Single frame:
  - Stimulus: frame bits 0-7 = 1, bits 8-63 alternate 1,0.
  - Required dec_cw: 56'hAA_AAAA_AAAA_AAAA.
  - Bench stub drives dec_data=32'hA5A5_3C3C and dec_err=8'b0000_0101 → out_data stream 1010_0101_1010_0101_0011_1100_0011_1100.
  - out_sof on bit 0 only; first out_valid at T+3; err_count=2, frame_count=1.
- Backpressure: out_ready low for 10 cycles mid-frame (after bit 5) → out_data/out_valid stable, no bit lost. Second frame fully received meanwhile → in_ready=0 until the FSM returns to O_EMPTY.
- Back-to-back: 3 frames streamed with continuous in_valid and out_ready=1 → 96 output bits in order; frame_count=3; exactly 2 idle cycles between output frames.
- Flush: assert flush at input bit 40 while O_SEND is at bit 12 → out_valid=0 next cycle, in_ready=1, in_cnt restarts. Counters unchanged.
- Saturation: preload via 8193 frames with dec_err=8'hFF (or force err_count=16'hFFFE) → err_count sticks at 16'hFFFF. frame_count wraps 16'hFFFF→0.
